// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared state encoding and default width for the shift sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module   : shift_sequencer_if
// Brief    : Control/serial bundle between system logic and the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
);

  logic             tick;
  logic             start;
  logic             abort;
  logic             msb_first;
  logic [WIDTH-1:0] load_data;
  logic             s_in;
  logic             s_out;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output tick, start, abort, msb_first, load_data, s_in,
    input  s_out, shift_en, busy, done, rx_data, bit_cnt
  );

  modport slave (
    input  tick, start, abort, msb_first, load_data, s_in,
    output s_out, shift_en, busy, done, rx_data, bit_cnt
  );

endinterface

`default_nettype wire

// File: rtl/shift_dual_sr.sv
// ============================================================================
// Module   : shift_dual_sr
// Brief    : Paired transmit/receive shift registers with latched bit order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_dual_sr
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_data,
  input  wire logic             i_msb_first,
  input  wire logic             i_shift,
  input  wire logic             i_s_in,
  output logic                  o_head,
  output logic [WIDTH-1:0]      o_rx_next
);

  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic             r_ord;

  assign o_head = r_ord ? r_tx[WIDTH-1] : r_tx[0];

  // Receive word as it will look once the current s_in is absorbed.
  assign o_rx_next = r_ord ? {r_rx[WIDTH-2:0], i_s_in}
                           : {i_s_in, r_rx[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_ord <= 1'b0;
    end else if (i_load) begin
      r_tx  <= i_load_data;
      r_rx  <= '0;
      r_ord <= i_msb_first;
    end else if (i_shift) begin
      r_tx  <= r_ord ? {r_tx[WIDTH-2:0], 1'b0} : {1'b0, r_tx[WIDTH-1:1]};
      r_rx  <= o_rx_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Brief    : Tick-paced serial transfer controller (FSM, bit counter, handshake).
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  shift_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_rx_data;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_in_shift;
  logic             w_load;
  logic             w_shift;
  logic             w_head;
  logic [WIDTH-1:0] w_rx_next;

  assign w_in_shift = (r_state == SHIFT);
  assign w_load     = (r_state == IDLE) && bus.start;
  // Abort wins over a coincident tick: no shift on the abort cycle.
  assign w_shift    = w_in_shift && bus.tick && !bus.abort;

  shift_dual_sr #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_data (bus.load_data),
    .i_msb_first (bus.msb_first),
    .i_shift     (w_shift),
    .i_s_in      (bus.s_in),
    .o_head      (w_head),
    .o_rx_next   (w_rx_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= SHIFT;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
          end else if (bus.tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_LAST) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_rx_data <= w_rx_next;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_out    = w_in_shift & w_head;
  assign bus.shift_en = w_shift;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rx_data  = r_rx_data;
  assign bus.bit_cnt  = r_bit_cnt;

endmodule

`default_nettype wire
